// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package bcd_pkg;

    // Converter FSM: waiting for a request, or shifting one operand bit per clock.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Double-dabble digit correction: a digit of 5 or more gets 3 added before
    // each shift, so the shift carries correctly into the next decimal digit.
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Smallest DIGITS that holds every result for a given operand width.
    // With signed operands the largest magnitude is 2^(w-1). Otherwise it is 2^w-1.
    function automatic int unsigned min_digits(input int unsigned w, input bit sgn);
        logic [63:0] v;
        int unsigned n;
        if (sgn)
            v = 64'd1 << (w - 1);
        else if (w >= 64)
            v = '1;
        else
            v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more.
// Latency: combinational.
// Backpressure: none (pure function of its input).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    // Correct the digit so the following left shift carries into the next digit.
    // The sum stays in 4 bits: the carry out is never needed.
    always_comb begin
        o_dig = (i_dig >= ADJ_THRESH) ? (i_dig + ADJ_ADD) : i_dig;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one operand bit per clock.
// Latency: done pulses in the cycle after edge accept+BIN_W; a new request can be accepted one edge later.
// Backpressure: start is ignored while busy; there is no queuing and bin_in is sampled only on the accept edge.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int BCD_W = 4 * DIGITS;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_pend;
    logic               r_done;
    logic               r_neg;
    logic [BCD_W-1:0]   r_bcd;

    logic               w_accept;
    logic               w_neg_in;
    logic [BIN_W-1:0]   w_mag;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_scratch_nxt;

    assign w_accept = (r_state == IDLE) && start;
    assign w_neg_in = (SIGNED != 0) && bin_in[BIN_W-1];
    // The most negative operand negates to itself. Read as an unsigned number,
    // that value is the correct magnitude 2^(BIN_W-1).
    assign w_mag    = w_neg_in ? (-bin_in) : bin_in;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_dig (r_scratch[4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    // The adjusted scratch shifts left by one and takes the next operand MSB.
    // The bit shifted out of the top digit is always zero when DIGITS is sized correctly.
    assign w_scratch_nxt = BCD_W'({w_adj, r_shift[BIN_W-1]});

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic: accept in IDLE, return to IDLE after the last shift.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)         w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == '0)   w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy comes from the state; the result and done come from registers.
    always_comb begin
        busy    = (r_state == SHIFT);
        done    = r_done;
        bcd_out = r_bcd;
        neg     = r_neg;
    end

    // Datapath: capture on accept, adjust and shift each SHIFT cycle, publish on the final shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_neg_pend <= 1'b0;
            r_done     <= 1'b0;
            r_neg      <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shift    <= w_mag;
                r_scratch  <= '0;
                r_cnt      <= CNT_W'(BIN_W - 1);
                r_neg_pend <= w_neg_in;
            end else if (r_state == SHIFT) begin
                r_scratch <= w_scratch_nxt;
                r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
                r_cnt     <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_bcd  <= w_scratch_nxt;
                    r_neg  <= r_neg_pend;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 16-bit/5-digit unsigned instance and an 8-bit/3-digit signed instance.
// Latency: results are expected BIN_W edges after the accept edge.
// Backpressure: starts issued while busy must be dropped.
module tb_bin2bcd_seq;
    import bcd_pkg::*;

    localparam int A_W = 16;
    localparam int A_D = 5;
    localparam int B_W = 8;
    localparam int B_D = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    logic              a_start = 1'b0;
    logic [A_W-1:0]    a_bin   = '0;
    logic              a_busy, a_done, a_neg;
    logic [4*A_D-1:0]  a_bcd;

    logic              b_start = 1'b0;
    logic [B_W-1:0]    b_bin   = '0;
    logic              b_busy, b_done, b_neg;
    logic [4*B_D-1:0]  b_bcd;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.BIN_W(A_W), .DIGITS(A_D), .SIGNED(0)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .bin_in(a_bin),
        .busy(a_busy), .done(a_done), .bcd_out(a_bcd), .neg(a_neg)
    );

    bin2bcd_seq #(.BIN_W(B_W), .DIGITS(B_D), .SIGNED(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .bin_in(b_bin),
        .busy(b_busy), .done(b_done), .bcd_out(b_bcd), .neg(b_neg)
    );

    // Decimal reference: peel off base-10 digits, units digit first.
    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Start a conversion on instance A and run until done. Also reports the edges
    // from accept to done, the busy cycles, and whether bcd_out held steady while busy.
    task automatic conv_a(input logic [A_W-1:0] v, output int lat, output int busy_n, output bit stable);
        logic [4*A_D-1:0] prev;
        prev    = a_bcd;
        a_bin   = v;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_bin   = ~v;
        lat = -1; busy_n = 0; stable = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (a_done) begin
                lat = k;
                break;
            end
            if (a_busy) busy_n++;
            if (a_bcd !== prev) stable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic conv_b(input logic [B_W-1:0] v, output int lat, output int busy_n, output bit stable);
        logic [4*B_D-1:0] prev;
        prev    = b_bcd;
        b_bin   = v;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_bin   = ~v;
        lat = -1; busy_n = 0; stable = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (b_done) begin
                lat = k;
                break;
            end
            if (b_busy) busy_n++;
            if (b_bcd !== prev) stable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pkg();
        checks++;
        if (min_digits(16, 1'b0) !== 5) begin
            errors++; $display("FAIL min_digits_16u: got %0d expected 5", min_digits(16, 1'b0));
        end
        checks++;
        if (min_digits(8, 1'b1) !== 3) begin
            errors++; $display("FAIL min_digits_8s: got %0d expected 3", min_digits(8, 1'b1));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_done, a_neg, a_bcd} !== '0) begin
            errors++; $display("FAIL reset_a: got busy=%b done=%b neg=%b bcd=%h expected all 0", a_busy, a_done, a_neg, a_bcd);
        end
        checks++;
        if ({b_busy, b_done, b_neg, b_bcd} !== '0) begin
            errors++; $display("FAIL reset_b: got busy=%b done=%b neg=%b bcd=%h expected all 0", b_busy, b_done, b_neg, b_bcd);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_done} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", a_busy, a_done);
        end
    endtask

    task automatic test_zero();
        int lat, bn;
        bit st;
        conv_a(16'd0, lat, bn, st);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL zero_latency: got %0d expected 16", lat); end
        checks++;
        if (bn !== 16) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 16", bn); end
        checks++;
        if (a_bcd !== 20'h00000 || a_neg !== 1'b0) begin
            errors++; $display("FAIL zero_result: got bcd=%h neg=%b expected 00000 0", a_bcd, a_neg);
        end
        @(posedge clk); #1;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL zero_done_pulse: got done=%b busy=%b expected 0 0", a_done, a_busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bn;
        bit st;
        conv_a(16'd65535, lat1, bn, st);
        checks++;
        if (a_bcd !== 20'h65535 || lat1 !== 16) begin
            errors++; $display("FAIL b2b_first: got bcd=%h lat=%0d expected 65535 16", a_bcd, lat1);
        end
        conv_a(16'd9999, lat2, bn, st);
        checks++;
        if (lat1 + 1 !== 17) begin errors++; $display("FAIL b2b_spacing: got %0d expected 17", lat1 + 1); end
        checks++;
        if (a_bcd !== 20'h09999 || lat2 !== 16) begin
            errors++; $display("FAIL b2b_second: got bcd=%h lat=%0d expected 09999 16", a_bcd, lat2);
        end
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL b2b_hold: got stable=%b expected 1", st); end
    endtask

    task automatic test_signed();
        logic [7:0]  vin  [4] = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        logic [11:0] ebcd [4] = '{12'h128, 12'h001, 12'h127, 12'h000};
        logic        eneg [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat, bn;
        bit st;
        for (int i = 0; i < 4; i++) begin
            conv_b(vin[i], lat, bn, st);
            checks++;
            if (b_bcd !== ebcd[i] || b_neg !== eneg[i] || lat !== 8 || bn !== 8) begin
                errors++;
                $display("FAIL signed_%h: got bcd=%h neg=%b lat=%0d busy=%0d expected %h %b 8 8",
                         vin[i], b_bcd, b_neg, lat, bn, ebcd[i], eneg[i]);
            end
        end
    endtask

    task automatic test_ignore_mid();
        int lat, done_n;
        lat = -1; done_n = 0;
        a_bin   = 16'd1234;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_bin   = 16'd4321;
        for (int k = 0; k < 40; k++) begin
            a_start = (k == 4);
            if (a_done) begin
                done_n++;
                if (lat < 0) lat = k;
            end
            @(posedge clk); #1;
        end
        a_start = 1'b0;
        checks++;
        if (a_bcd !== 20'h01234) begin errors++; $display("FAIL mid_start_result: got %h expected 01234", a_bcd); end
        checks++;
        if (done_n !== 1 || lat !== 16) begin
            errors++; $display("FAIL mid_start_done: got pulses=%0d lat=%0d expected 1 16", done_n, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bn, done_n;
        bit st;
        a_bin   = 16'd40000;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_bcd !== 20'h0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b bcd=%h expected 0 0 00000", a_busy, a_done, a_bcd);
        end
        reset = 1'b0;
        done_n = 0;
        for (int k = 0; k < 30; k++) begin
            if (a_done) done_n++;
            @(posedge clk); #1;
        end
        checks++;
        if (done_n !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d expected 0", done_n); end
        conv_a(16'd40000, lat, bn, st);
        checks++;
        if (a_bcd !== 20'h40000 || lat !== 16) begin
            errors++; $display("FAIL reset_mid_rerun: got bcd=%h lat=%0d expected 40000 16", a_bcd, lat);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] r;
        logic [A_W-1:0] va;
        logic [B_W-1:0] vb;
        int lat, bn, sv;
        int unsigned mag;
        bit st;
        for (int i = 0; i < 1000; i++) begin
            va = A_W'($urandom);
            conv_a(va, lat, bn, st);
            r = ref_bcd(int'(va));
            checks++;
            if (a_bcd !== r[19:0] || a_neg !== 1'b0 || lat !== 16 || st !== 1'b1) begin
                errors++;
                $display("FAIL sweep_u_%0d: got bcd=%h neg=%b lat=%0d stable=%b expected %h 0 16 1",
                         va, a_bcd, a_neg, lat, st, r[19:0]);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            vb = B_W'($urandom);
            conv_b(vb, lat, bn, st);
            sv  = int'($signed(vb));
            mag = (sv < 0) ? int'(-sv) : int'(sv);
            r = ref_bcd(mag);
            checks++;
            if (b_bcd !== r[11:0] || b_neg !== vb[7] || lat !== 8 || st !== 1'b1) begin
                errors++;
                $display("FAIL sweep_s_%h: got bcd=%h neg=%b lat=%0d stable=%b expected %h %b 8 1",
                         vb, b_bcd, b_neg, lat, st, r[11:0], vb[7]);
            end
        end
    endtask

    initial begin
        test_pkg();
        test_reset();
        test_zero();
        test_back_to_back();
        test_signed();
        test_ignore_mid();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
